// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared maze geometry defaults, colours and FSM/direction types
package maze_pkg;

  localparam int DEF_WIDTH  = 96;
  localparam int DEF_HEIGHT = 64;

  localparam logic [15:0] WALL   = 16'hFFFF;
  localparam logic [15:0] GOAL   = 16'h001F;
  localparam logic [15:0] PLAYER = 16'hF800;
  localparam logic [15:0] WIN    = 16'h07E0;

  typedef enum logic [1:0] {IDLE, PROBE, DRAIN, COMMIT} state_e;
  typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_e;

endpackage

// File: rtl/maze_collision_probe.sv
// rtl/maze_collision_probe.sv - move-check FSM walking the candidate's leading edge on the ROM probe port
module maze_collision_probe
  import maze_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SPRITE = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  dir_e        req_dir,
  input  logic [6:0]  pos_x,
  input  logic [5:0]  pos_y,
  input  logic [15:0] probe_data,
  output logic [12:0] probe_index,
  output logic        busy,
  output logic        commit,
  output logic [6:0]  new_x,
  output logic [5:0]  new_y,
  output logic        goal
);

  localparam int CW = (SPRITE > 1) ? $clog2(SPRITE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SPRITE - 1);

  state_e          state_q, state_d;
  dir_e            dir_q, dir_d;
  logic [6:0]      nx_q, nx_d, cand_x;
  logic [5:0]      ny_q, ny_d, cand_y;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            blocked_q, blocked_d;
  logic            goal_q, goal_d;
  logic            eval_q, eval_d;
  logic [12:0]     probe_index_q, probe_index_d;

  // Address of leading-edge pixel k for a sprite whose top-left is (x, y).
  function automatic logic [12:0] edge_addr(dir_e d, logic [6:0] x, logic [5:0] y,
                                            logic [CW-1:0] k);
    logic [12:0] ex, ey;
    ex = 13'(x);
    ey = 13'(y);
    case (d)
      UP:      ex = ex + 13'(k);
      DOWN:    begin ex = ex + 13'(k); ey = ey + 13'(SPRITE - 1); end
      LEFT:    ey = ey + 13'(k);
      default: begin ex = ex + 13'(SPRITE - 1); ey = ey + 13'(k); end
    endcase
    return ey * 13'(WIDTH) + ex;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = PROBE;
      PROBE:   if (cnt_q == LAST) state_d = DRAIN;
      DRAIN:   state_d = COMMIT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cand_x = pos_x;
    cand_y = pos_y;
    case (req_dir)
      UP:      cand_y = pos_y - 6'd1;
      DOWN:    cand_y = pos_y + 6'd1;
      LEFT:    cand_x = pos_x - 7'd1;
      default: cand_x = pos_x + 7'd1;
    endcase
  end

  // Probe address is registered one step ahead so address k is on the port during PROBE cycle k.
  always_comb begin
    dir_d         = dir_q;
    nx_d          = nx_q;
    ny_d          = ny_q;
    cnt_d         = cnt_q;
    blocked_d     = blocked_q;
    goal_d        = goal_q;
    probe_index_d = probe_index_q;
    eval_d        = (state_q == PROBE);
    if (state_q == IDLE && req) begin
      dir_d         = req_dir;
      nx_d          = cand_x;
      ny_d          = cand_y;
      cnt_d         = '0;
      blocked_d     = 1'b0;
      goal_d        = 1'b0;
      probe_index_d = edge_addr(req_dir, cand_x, cand_y, '0);
    end else if (state_q == PROBE) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q != LAST) probe_index_d = edge_addr(dir_q, nx_q, ny_q, cnt_q + 1'b1);
    end
    if (eval_q) begin
      if (probe_data == WALL) blocked_d = 1'b1;
      if (probe_data == GOAL) goal_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dir_q         <= UP;
      nx_q          <= '0;
      ny_q          <= '0;
      cnt_q         <= '0;
      blocked_q     <= 1'b0;
      goal_q        <= 1'b0;
      eval_q        <= 1'b0;
      probe_index_q <= '0;
    end else begin
      dir_q         <= dir_d;
      nx_q          <= nx_d;
      ny_q          <= ny_d;
      cnt_q         <= cnt_d;
      blocked_q     <= blocked_d;
      goal_q        <= goal_d;
      eval_q        <= eval_d;
      probe_index_q <= probe_index_d;
    end
  end

  always_comb begin
    busy        = (state_q != IDLE);
    commit      = (state_q == COMMIT) && !blocked_q;
    goal        = goal_q;
    new_x       = nx_q;
    new_y       = ny_q;
    probe_index = probe_index_q;
  end

endmodule

// File: rtl/maze_player_overlay.sv
// rtl/maze_player_overlay.sv - player sprite position, win flag and display overlay
// MAZE_WIN_BLINK_EN: blink the win sprite with a move_tick-driven counter.
module maze_player_overlay
  import maze_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int HEIGHT  = DEF_HEIGHT,
  parameter int SPRITE  = 5,
  parameter int START_X = 5,
  parameter int START_Y = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        move_tick,
  input  logic        btn_u,
  input  logic        btn_d,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic [12:0] pixel_index,
  input  logic [15:0] maze_data,
  output logic [12:0] probe_index,
  input  logic [15:0] probe_data,
  output logic [15:0] oled_data,
  output logic [6:0]  player_x,
  output logic [5:0]  player_y,
  output logic        win,
  output logic        busy
);

  logic [6:0]  player_x_q, player_x_d, new_x;
  logic [5:0]  player_y_q, player_y_d, new_y;
  logic        win_q, win_d;
  logic [12:0] pix_q, pix_d;
  logic [15:0] oled_q, oled_d;
  logic [12:0] pix_x, pix_y, spr_x, spr_y;
  logic        in_sprite, hide, in_bounds, req, commit, goal;
  dir_e        req_dir;

  // A move is only requested when the candidate stays on screen; off-screen moves never start a probe.
  always_comb begin
    req_dir   = UP;
    in_bounds = 1'b0;
    if (btn_u) begin
      req_dir   = UP;
      in_bounds = (player_y_q != '0);
    end else if (btn_d) begin
      req_dir   = DOWN;
      in_bounds = (int'(player_y_q) + SPRITE != HEIGHT);
    end else if (btn_l) begin
      req_dir   = LEFT;
      in_bounds = (player_x_q != '0);
    end else if (btn_r) begin
      req_dir   = RIGHT;
      in_bounds = (int'(player_x_q) + SPRITE != WIDTH);
    end
  end

  assign req = move_tick && !win_q && !busy && in_bounds;

  maze_collision_probe #(
    .WIDTH  (WIDTH),
    .SPRITE (SPRITE)
  ) u_probe (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_dir     (req_dir),
    .pos_x       (player_x_q),
    .pos_y       (player_y_q),
    .probe_data  (probe_data),
    .probe_index (probe_index),
    .busy        (busy),
    .commit      (commit),
    .new_x       (new_x),
    .new_y       (new_y),
    .goal        (goal)
  );

`ifdef MAZE_WIN_BLINK_EN
  logic [3:0] blink_q, blink_d;

  always_comb begin
    blink_d = blink_q;
    if (win_q && move_tick) blink_d = blink_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) blink_q <= '0;
    else        blink_q <= blink_d;
  end

  assign hide = blink_q[3];
`else
  assign hide = 1'b0;
`endif

  always_comb begin
    pix_x     = pix_q % 13'(WIDTH);
    pix_y     = pix_q / 13'(WIDTH);
    spr_x     = 13'(player_x_q);
    spr_y     = 13'(player_y_q);
    in_sprite = (pix_x >= spr_x) && (pix_x < spr_x + 13'(SPRITE)) &&
                (pix_y >= spr_y) && (pix_y < spr_y + 13'(SPRITE));
    pix_d     = pixel_index;
    oled_d    = maze_data;
    if (in_sprite && !hide) oled_d = win_q ? WIN : PLAYER;
  end

  always_comb begin
    player_x_d = player_x_q;
    player_y_d = player_y_q;
    win_d      = win_q;
    if (commit) begin
      player_x_d = new_x;
      player_y_d = new_y;
      if (goal) win_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      player_x_q <= 7'(START_X);
      player_y_q <= 6'(START_Y);
      win_q      <= 1'b0;
      pix_q      <= '0;
      oled_q     <= '0;
    end else begin
      player_x_q <= player_x_d;
      player_y_q <= player_y_d;
      win_q      <= win_d;
      pix_q      <= pix_d;
      oled_q     <= oled_d;
    end
  end

  assign player_x  = player_x_q;
  assign player_y  = player_y_q;
  assign win       = win_q;
  assign oled_data = oled_q;

endmodule

// File: tb/tb_maze_player_overlay.sv
// tb/tb_maze_player_overlay.sv - directed scoreboard bench with a behavioural maze ROM
module tb_maze_player_overlay;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        move_tick = 1'b0;
  logic        btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0;
  logic [12:0] pixel_index = '0;
  logic [15:0] maze_data = '0;
  logic [12:0] probe_index;
  logic [15:0] probe_data = '0;
  logic [15:0] oled_data;
  logic [6:0]  player_x;
  logic [5:0]  player_y;
  logic        win;
  logic        busy;

  int errors = 0;
  int checks = 0;

  int         mx = 5, my = 5;
  logic       mwin = 1'b0;
`ifdef MAZE_WIN_BLINK_EN
  logic [3:0] mblink = '0;
`endif

  logic [15:0] pix_exp[$];
  logic [13:0] mv_exp[$];
  int          stim[$];

  maze_player_overlay dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .move_tick   (move_tick),
    .btn_u       (btn_u),
    .btn_d       (btn_d),
    .btn_l       (btn_l),
    .btn_r       (btn_r),
    .pixel_index (pixel_index),
    .maze_data   (maze_data),
    .probe_index (probe_index),
    .probe_data  (probe_data),
    .oled_data   (oled_data),
    .player_x    (player_x),
    .player_y    (player_y),
    .win         (win),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Border walls on top, bottom and right; left columns open; goal patch at rows 52..55, cols 5..9.
  function automatic logic [15:0] maze_px(int idx);
    int x, y;
    x = idx % 96;
    y = idx / 96;
    if (y <= 2 || y >= 61 || x >= 93) return 16'hFFFF;
    if (y >= 52 && y <= 55 && x >= 5 && x <= 9) return 16'h001F;
    return 16'h0000;
  endfunction

  always @(posedge clk) begin
    maze_data  <= maze_px(int'(pixel_index));
    probe_data <= maze_px(int'(probe_index));
  end

  function automatic logic [15:0] exp_pix(int idx);
    int   x, y;
    logic hide;
    x = idx % 96;
    y = idx / 96;
    hide = 1'b0;
`ifdef MAZE_WIN_BLINK_EN
    hide = mblink[3];
`endif
    if (x >= mx && x < mx + 5 && y >= my && y < my + 5 && !hide)
      return mwin ? 16'h07E0 : 16'hF800;
    return maze_px(idx);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_stream();
    for (int i = 0; i < stim.size() + 2; i++) begin
      @(negedge clk);
      if (i >= 2) chk("pixel", 32'(oled_data), 32'(pix_exp.pop_front()));
      if (i < stim.size()) begin
        pixel_index = 13'(stim[i]);
        pix_exp.push_back(exp_pix(stim[i]));
      end
    end
    stim.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mx = 5; my = 5; mwin = 1'b0;
`ifdef MAZE_WIN_BLINK_EN
    mblink = '0;
`endif
  endtask

  task automatic do_move(input string tag, input logic u, input logic d,
                         input logic l, input logic r);
    int   nx, ny, px, py, ebusy, bc;
    logic blk, gl;
    logic [15:0] c;
    ebusy = 0;
    if (mwin) begin
`ifdef MAZE_WIN_BLINK_EN
      mblink = mblink + 4'd1;
`endif
    end else if (u || d || l || r) begin
      nx = mx; ny = my;
      if (u) ny = my - 1; else if (d) ny = my + 1; else if (l) nx = mx - 1; else nx = mx + 1;
      if (nx >= 0 && ny >= 0 && nx + 5 <= 96 && ny + 5 <= 64) begin
        ebusy = 7; blk = 1'b0; gl = 1'b0;
        for (int k = 0; k < 5; k++) begin
          px = (u || d) ? nx + k : (l ? nx : nx + 4);
          py = u ? ny : (d ? ny + 4 : ny + k);
          c = maze_px(py * 96 + px);
          if (c == 16'hFFFF) blk = 1'b1;
          if (c == 16'h001F) gl = 1'b1;
        end
        if (!blk) begin
          mx = nx; my = ny;
          if (gl) mwin = 1'b1;
        end
      end
    end
    mv_exp.push_back({7'(mx), 6'(my), mwin});
    @(negedge clk);
    btn_u = u; btn_d = d; btn_l = l; btn_r = r;
    move_tick = 1'b1;
    @(negedge clk);
    move_tick = 1'b0;
    btn_u = 1'b0; btn_d = 1'b0; btn_l = 1'b0; btn_r = 1'b0;
    bc = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      if (busy) bc++;
    end
    chk({tag, " busy cycles"}, 32'(bc), 32'(ebusy));
    chk({tag, " pos/win"}, 32'({player_x, player_y, win}), 32'(mv_exp.pop_front()));
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset oled", 32'(oled_data), 32'h0);
    chk("reset probe_index", 32'(probe_index), 32'h0);
    chk("reset pos", 32'({player_x, player_y}), 32'({7'd5, 6'd5}));
    chk("reset win/busy", 32'({win, busy}), 32'h0);
    rst_n = 1'b1;

    // Display path, back-to-back pixels including sprite edges
    stim = '{485, 0, 1000, 873, 490, 484, 389};
    run_stream();

    // Wall block going up
    do_move("up1", 1, 0, 0, 0);
    chk("up1 y", 32'(player_y), 32'd4);
    do_move("up2", 1, 0, 0, 0);
    chk("up2 y", 32'(player_y), 32'd3);
    do_move("up3", 1, 0, 0, 0);
    chk("up3 y", 32'(player_y), 32'd3);

    // Priority: up beats right
    do_reset();
    do_move("prio", 1, 0, 0, 1);
    chk("prio pos", 32'({player_x, player_y}), 32'({7'd5, 6'd4}));

    // Left edge of the screen
    do_reset();
    for (int i = 0; i < 5; i++) do_move("left", 0, 0, 1, 0);
    chk("left x", 32'(player_x), 32'd0);
    do_move("left edge", 0, 0, 1, 0);

    // Right sweep into the right wall
    do_reset();
    for (int i = 0; i < 84; i++) do_move("right", 0, 0, 0, 1);
    chk("right x", 32'(player_x), 32'd88);

    // Down to the goal, then moves are ignored
    do_reset();
    for (int i = 0; i < 43; i++) do_move("down", 0, 1, 0, 0);
    chk("goal y/win", 32'({player_y, win}), 32'({6'd48, 1'b1}));
    do_move("after win", 0, 1, 0, 0);
    stim = '{4613, 4617, 5001, 4612};
    run_stream();
    for (int i = 0; i < 8; i++) do_move("win tick", 0, 0, 0, 0);
    stim = '{4613, 5001};
    run_stream();

    // Reset in the middle of a check
    do_reset();
    do_move("pre", 0, 1, 0, 0);
    @(negedge clk);
    btn_d = 1'b1;
    move_tick = 1'b1;
    @(negedge clk);
    move_tick = 1'b0;
    btn_d = 1'b0;
    chk("mid busy", 32'(busy), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid busy after rst", 32'(busy), 32'h0);
    chk("mid pos after rst", 32'({player_x, player_y, win}), 32'({7'd5, 6'd5, 1'b0}));
    rst_n = 1'b1;
    mx = 5; my = 5; mwin = 1'b0;
    do_move("post rst", 0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/maze_player_overlay.md
# maze_player_overlay

Downstream stage of the 96×64 maze pixel ROM. Composites a movable 5×5 player sprite over the maze pixel stream before the OLED driver. Moves the player on debounced buttons, gated by a rate strobe. Each candidate move is collision-checked against wall and goal colours through a dedicated probe port on a second maze-ROM instance.

## Interface
- WIDTH, 96: screen width in pixels.
- HEIGHT, 64: screen height in pixels.
- SPRITE, 5: sprite edge length in pixels.
- START_X, 5 / START_Y, 5: sprite top-left corner after reset.
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- move_tick  in  1  one-cycle movement-rate strobe.
- btn_u, btn_d, btn_l, btn_r  in  1 each  debounced, level-sensitive buttons.
- pixel_index  in  13  OLED scan index, y*WIDTH+x.
- maze_data  in  16  display-port ROM output, valid 1 cycle after pixel_index.
- probe_index  out  13  probe-port ROM address.
- probe_data  in  16  probe-port ROM output, valid 1 cycle after probe_index.
- oled_data  out  16  composited RGB565 pixel, registered.
- player_x  out  7 / player_y  out  6  sprite top-left corner.
- win  out  1  sticky goal-reached flag.
- busy  out  1  move check in progress.

## Operation
- Colours: wall 16'hFFFF, goal 16'h001F, player 16'hF800, win sprite 16'h07E0. Any other probed value counts as open.
- Display path:
  - pixel_index is delayed one cycle to align with maze_data.
  - If the aligned pixel lies in [player_x, player_x+SPRITE-1] × [player_y, player_y+SPRITE-1], the output is the sprite colour. Otherwise it is maze_data.
  - The sprite colour is player colour while win=0 and win colour once win=1.
- FSM states: IDLE, PROBE, DRAIN, COMMIT.
- IDLE:
  - move_tick with win=0 selects one direction by priority U > D > L > R.
  - No button pressed → stay in IDLE.
  - If the candidate position would leave the screen (y==0 up, y+SPRITE==HEIGHT down, x==0 left, x+SPRITE==WIDTH right), the move is dropped and the FSM stays in IDLE.
  - Otherwise latch direction and candidate (nx, ny), clear blocked/goal_seen, go to PROBE.
- PROBE runs SPRITE cycles. Cycle k issues the leading-edge pixel k of the candidate:
  - up: (nx+k, ny).
  - down: (nx+k, ny+SPRITE-1).
  - left: (nx, ny+k).
  - right: (nx+SPRITE-1, ny+k).
- Each probe_data is evaluated the cycle after issue: wall sets blocked, goal sets goal_seen.
- DRAIN runs one cycle to evaluate the last probe.
- COMMIT:
  - If not blocked, the position takes (nx, ny).
  - If not blocked and goal_seen, win is set.
  - If blocked, the position is unchanged.
  - Return to IDLE.
- Buttons are latched at acceptance; button changes during a check are ignored. move_tick is ignored while busy and is not queued.
- win is sticky until reset. After win, all moves are ignored.
- Reset overrides everything, including mid-check. Reset values:
  - FSM = IDLE.
  - oled_data = 0, probe_index = 0.
  - player_x = START_X, player_y = START_Y.
  - win = 0, busy = 0.

## Timing
- Display latency: pixel_index at cycle t → oled_data at t+2 (1 cycle ROM + 1 cycle overlay register). Throughput is one pixel per cycle.
- Move accepted at cycle T:
  - PROBE occupies T+1..T+SPRITE.
  - DRAIN is at T+SPRITE+1; COMMIT is at T+SPRITE+2.
  - New player_x/player_y/win are visible at T+SPRITE+3.
  - busy is high for T+1..T+SPRITE+2.
- A position change mid-frame is allowed to tear one frame.
- Index arithmetic is 13-bit unsigned, y*WIDTH+x; it never overflows given the boundary checks.

## Configuration
- MAZE_WIN_BLINK_EN defined:
  - A 4-bit counter increments on every move_tick while win=1.
  - The sprite is suppressed (maze_data shown) while counter bit 3 is 1, giving a blink period of 16 ticks.
  - The counter resets to 0.
- Undefined: the win sprite is steady 16'h07E0 and the counter is not built.

## Structure
- Package maze_pkg holds:
  - WIDTH/HEIGHT defaults.
  - Colour constants WALL, GOAL, PLAYER, WIN.
  - State enum {IDLE, PROBE, DRAIN, COMMIT}.
  - Direction enum {UP, DOWN, LEFT, RIGHT}.
- Sub-module maze_collision_probe contains the FSM, probe addressing and blocked/goal evaluation. It takes the current position and direction, and returns a commit pulse, the new position and the goal flag. The top level owns the position registers, win and the display overlay.

## Test plan
- Display: after reset, pixel_index=485 (5,5) → oled_data=16'hF800 two cycles later; pixel_index=0 → 16'hFFFF; pixel_index=1000 (40,10) → 16'h0000.
- Wall block up: from (5,5), three up ticks → y=4,3,3; the third probes row 2 and sets blocked, busy is high for SPRITE+2 cycles, and player_y is unchanged.
- Right sweep: btn_r held at y=5 → x reaches 88 after 83 ticks; the 84th tick (probe col 93) is blocked and x stays 88.
- Goal: btn_d held at x=5 → the 43rd tick gives y=48 with win=1 at T+SPRITE+3; a further tick leaves y=48; the sprite reads 16'h07E0 (steady) or blinks every 8 ticks with MAZE_WIN_BLINK_EN.
- Boundary / priority: at x=0 a left tick → no PROBE, busy stays 0; btn_u+btn_r together → up only.
- Reset mid-check: rst_n=0 during PROBE → next cycle FSM = IDLE, position (5,5), win=0, busy=0.
